// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam int INSTR_W = 32;

  // Bit 0 is the MSB, matching the instruction memory's numbering.
  typedef logic [0:INSTR_W-1] word_t;

  localparam word_t NOP_INSTR        = 32'h0000_0000;
  localparam word_t PC_STEP          = 32'd4;
  localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_hold_buf.sv
// Hold register for the IF/ID instruction word while decode stalls, plus the
// output mux that picks the held word, the live memory word, or a NOP.
module fetch_hold_buf
  import fetch_unit_pkg::*;
(
  input  logic  clk,
  input  logic  capture,
  input  logic  clear,
  input  logic  word_valid,
  input  word_t in_word,
  output word_t out_word,
  output logic  out_sel
);

  logic  hold_valid_q;
  word_t hold_q;

  // Valid bit: clear wins, so reset/redirect/advance always release the hold.
  always_ff @(posedge clk) begin
    if (clear) begin
      hold_valid_q <= 1'b0;
    end else if (capture) begin
      hold_valid_q <= 1'b1;
    end
  end

  // Data capture: no reset needed, the valid bit qualifies the contents.
  always_ff @(posedge clk) begin
    if (capture && !clear) begin
      hold_q <= in_word;
    end
  end

  assign out_sel = hold_valid_q;

  // Output mux: NOP when the bundle is empty, else held word over live word.
  always_comb begin
    out_word = NOP_INSTR;
    if (word_valid) begin
      out_word = hold_valid_q ? hold_q : in_word;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory and
// aligns the memory's registered read data with the PC that produced it.
// Handles decode stall, EX redirect with squash, and a sticky fetch fault.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter word_t RESET_PC  = DEFAULT_RESET_PC,
  parameter int    MEM_BYTES = 2048
) (
  input  logic  clk,
  input  logic  reset,
  output word_t imem_addr,
  input  word_t imem_instr,
  input  logic  stall,
  input  logic  redirect_valid,
  input  word_t redirect_target,
  output logic  id_valid,
  output word_t id_instr,
  output word_t id_pc,
  output word_t id_pc_plus4,
  output logic  fetch_fault
);

  // MEM_BYTES is a power of two, so the modulo reduces to a mask.
  localparam word_t ADDR_MASK = MEM_BYTES - 1;
  localparam word_t MEM_LIMIT = MEM_BYTES;

  // Sequential next PC, wrapping at the top of instruction memory.
  function automatic word_t wrap_pc(input word_t pc);
    return (pc + PC_STEP) & ADDR_MASK;
  endfunction

  // A redirect target must be word aligned and inside instruction memory.
  function automatic logic target_illegal(input word_t target);
    return (target[30:31] != 2'b00) || (target >= MEM_LIMIT);
  endfunction

  word_t pc_q;
  word_t id_pc_q;
  logic  id_valid_q;
  logic  fault_q;

  logic  take_stall;
  logic  hold_sel;
  logic  hold_capture;
  logic  hold_clear;

  // A stall only counts when neither the fault nor a redirect overrides it.
  assign take_stall   = !fault_q && !redirect_valid && stall;
  // Capture only on the first stall edge: the memory output is about to be
  // replaced by the next word, so the current one must be saved now.
  assign hold_capture = take_stall && !hold_sel;
  assign hold_clear   = reset || !take_stall;

  // PC and IF/ID control: reset > fault > redirect > stall > advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      fault_q    <= 1'b0;
    end else if (fault_q) begin
      id_valid_q <= 1'b0;
    end else if (redirect_valid) begin
      // The word landing in memory this edge is wrong-path: squash it.
      id_valid_q <= 1'b0;
      if (target_illegal(redirect_target)) begin
        fault_q <= 1'b1;
      end else begin
        pc_q <= redirect_target;
      end
    end else if (!stall) begin
      // Memory reads pc_q this edge, so the bundle's PC is pc_q too.
      pc_q       <= wrap_pc(pc_q);
      id_valid_q <= 1'b1;
      id_pc_q    <= pc_q;
    end
  end

  fetch_hold_buf u_hold_buf (
    .clk        (clk),
    .capture    (hold_capture),
    .clear      (hold_clear),
    .word_valid (id_valid_q),
    .in_word    (imem_instr),
    .out_word   (id_instr),
    .out_sel    (hold_sel)
  );

  assign imem_addr   = pc_q;
  assign id_valid    = id_valid_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = wrap_pc(id_pc_q);
  assign fetch_fault = fault_q;

endmodule
